fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined MIPS core. It directly feeds the fetch/decode pipeline register. It owns the PC, issues one-outstanding-request reads to instruction memory over a ready/valid handshake, and applies branch/jump redirects from decode. It presents either a valid instruction or a NOP bubble (0x00000000) plus PC+4 to the fetch/decode register every cycle.

## Interface
- DATA_WIDTH, 32, instruction/PC width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stallF  in  1  hazard unit: hold PC/instruction; fetch/decode register does not load
- branch_takenD  in  1  taken branch resolved in decode
- branch_targetD  in  DATA_WIDTH  branch target
- jumpD  in  1  jump in decode (priority over branch)
- jump_targetD  in  DATA_WIDTH  jump target
- imem_req  out  1  read request
- imem_addr  out  DATA_WIDTH  read address (= pc)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  DATA_WIDTH  read data
- instructionF  out  DATA_WIDTH  instruction to fetch/decode register; 0 when not valid
- pc_plus4F  out  DATA_WIDTH  pc + 4
- fetch_validF  out  1  instructionF holds a real instruction
- flushD  out  1  redirect accepted; fetch/decode register must clear

## Operation
- Registers: pc, ibuf (DATA_WIDTH), state in {S_REQ, S_WAIT, S_VALID, S_DROP}.
- redirect = (jumpD | branch_takenD) & ~stallF. target = jumpD ? jump_targetD : branch_targetD, low 2 bits forced to 0. flushD = redirect (combinational).
- Redirects arriving while stallF=1 are ignored; the hazard unit re-presents them.
- S_REQ: imem_req=1, imem_addr=pc.
  - Redirect: pc<=target. If imem_ready=1, go S_DROP (wrong-path request is in flight). Otherwise stay S_REQ.
  - Else if imem_ready=1: go S_WAIT.
- S_WAIT: imem_req=0.
  - Redirect: pc<=target. If imem_rvalid=1, go S_REQ. Otherwise go S_DROP.
  - Else if imem_rvalid=1: ibuf<=imem_rdata, go S_VALID.
- S_VALID: instructionF=ibuf, fetch_validF=1.
  - Redirect: pc<=target, go S_REQ; ibuf is discarded.
  - Else if stallF=0: instruction consumed, pc<=pc+4, go S_REQ.
  - Else hold.
- S_DROP: imem_req=0. On imem_rvalid, discard the data and go S_REQ. A redirect here updates pc and stays in S_DROP.
- Whenever fetch_validF=0: instructionF=0 (NOP bubble). pc_plus4F=pc+4 always.
- Arithmetic: pc+4 is modulo 2^DATA_WIDTH; 0xFFFFFFFC wraps to 0x00000000.
- Memory contract: rvalid is never asserted in the same cycle a request is accepted, and at most one request is outstanding.

## Timing
- Reset values: pc=RESET_PC, ibuf=0, state=S_REQ.
- While rst=1 outputs are: imem_req=0 (gated), imem_addr=RESET_PC, instructionF=0, pc_plus4F=RESET_PC+4, fetch_validF=0, flushD=0.
- Reset mid-request: any outstanding response arriving after rst deasserts is the memory's responsibility to squash. Fetch restarts cleanly in S_REQ.
- Zero-wait memory (ready in S_REQ, rvalid the next cycle), no stall: one instruction every 3 cycles (REQ, WAIT, VALID). With FETCH_BYPASS_EN, one every 2 cycles.
- flushD and the pc update occur in the same cycle as the redirect inputs. The first target-path request issues the following cycle, unless a drop is pending.
- stallF=1 never changes pc.

## Configuration
- FETCH_BYPASS_EN defined: in S_WAIT with imem_rvalid=1 and no redirect, instructionF=imem_rdata and fetch_validF=1 combinationally.
  - If stallF=0: pc<=pc+4, go S_REQ, skipping S_VALID.
  - If stallF=1: ibuf<=imem_rdata, go S_VALID.
- FETCH_BYPASS_EN undefined: data always goes through ibuf/S_VALID. fetch_validF is driven only from S_VALID.

## Test plan
- Reset with RESET_PC=0x00400000, zero-wait memory, no stall -> imem_addr sequence 0x00400000, 0x00400004, 0x00400008; fetch_validF pulses every 3rd cycle (every 2nd with FETCH_BYPASS_EN); instructionF=0 in between.
- stallF=1 for 4 cycles while in S_VALID with ibuf=0x8C220004 -> instructionF, pc and pc_plus4F held constant; no new imem_req; release resumes at pc+4.
- branch_takenD=1, branch_targetD=0x00400103 in S_VALID -> flushD=1 that cycle, ibuf discarded, next imem_addr=0x00400100.
- Jump in S_WAIT before rvalid, jump_targetD=0x00000040 -> S_DROP; returning data is not presented (fetch_validF stays 0); next imem_addr=0x00000040.
- Simultaneous jumpD=1 (target 0x100) and branch_takenD=1 (target 0x200) -> pc=0x100; redirect with stallF=1 -> ignored, flushD=0.
- pc=0xFFFFFFFC -> pc_plus4F=0x00000000, next fetch at 0x00000000. rst pulsed in S_WAIT -> outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage: PC, single-outstanding imem read, branch/jump redirect
//
// Optional feature macro: FETCH_BYPASS_EN (forward read data to the decode register straight
// from S_WAIT instead of always staging it through ibuf/S_VALID).
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   stallF                        hold PC/instruction; decode register does not load
//   branch_takenD/branch_targetD  taken branch from decode
//   jumpD/jump_targetD            jump from decode (wins over branch)
//   imem_req/imem_addr            read request and address (address is always pc)
//   imem_ready                    memory accepts the request this cycle
//   imem_rvalid/imem_rdata        read response
//   instructionF                  instruction to fetch/decode register, 0 when not valid
//   pc_plus4F                     pc + 4
//   fetch_validF                  instructionF holds a real instruction
//   flushD                        redirect accepted; fetch/decode register must clear

module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stallF,
    input  logic                  branch_takenD,
    input  logic [DATA_WIDTH-1:0] branch_targetD,
    input  logic                  jumpD,
    input  logic [DATA_WIDTH-1:0] jump_targetD,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instructionF,
    output logic [DATA_WIDTH-1:0] pc_plus4F,
    output logic                  fetch_validF,
    output logic                  flushD
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID, S_DROP} state_t;

    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   ibuf_q, ibuf_d;
    logic [DATA_WIDTH-1:0]   pc_plus4;
    logic [DATA_WIDTH-1:0]   target_raw;
    logic [DATA_WIDTH-1:0]   target;
    logic                    redirect;

    // A stalled redirect is dropped here; the hazard unit presents it again.
    assign redirect   = (jumpD | branch_takenD) & ~stallF;
    assign target_raw = jumpD ? jump_targetD : branch_targetD;
    assign target     = target_raw & ALIGN_MASK;
    assign pc_plus4   = pc_q + PC_STEP;

    assign flushD     = redirect & ~rst;
    assign imem_addr  = pc_q;
    assign pc_plus4F  = pc_plus4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            ibuf_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ibuf_q  <= ibuf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ibuf_d       = ibuf_q;
        imem_req     = 1'b0;
        instructionF = '0;
        fetch_validF = 1'b0;

        case (state_q)
            S_REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_d = target;
                    // An accepted request now belongs to the wrong path.
                    if (imem_ready) state_d = S_DROP;
                end else if (imem_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
`ifdef FETCH_BYPASS_EN
                    instructionF = imem_rdata;
                    fetch_validF = 1'b1;
                    if (!stallF) begin
                        pc_d    = pc_plus4;
                        state_d = S_REQ;
                    end else begin
                        ibuf_d  = imem_rdata;
                        state_d = S_VALID;
                    end
`else
                    ibuf_d  = imem_rdata;
                    state_d = S_VALID;
`endif
                end
            end
            S_VALID: begin
                instructionF = ibuf_q;
                fetch_validF = 1'b1;
                if (redirect) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (!stallF) begin
                    pc_d    = pc_plus4;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                // pc may still be retargeted while the stale response is pending.
                if (redirect) pc_d = target;
                if (imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        if (rst) imem_req = 1'b0;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with a zero-wait memory model
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h0040_0000;
`ifdef FETCH_BYPASS_EN
    localparam int P = 2;
`else
    localparam int P = 3;
`endif

    logic        clk, rst, stallF, branch_takenD, jumpD;
    logic [31:0] branch_targetD, jump_targetD;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata, instructionF, pc_plus4F;
    logic        fetch_validF, flushD;

    fetch_stage #(.DATA_WIDTH(32), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .stallF(stallF),
        .branch_takenD(branch_takenD), .branch_targetD(branch_targetD),
        .jumpD(jumpD), .jump_targetD(jump_targetD),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instructionF(instructionF), .pc_plus4F(pc_plus4F),
        .fetch_validF(fetch_validF), .flushD(flushD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pcp4;
    } sb_t;

    typedef struct {
        logic        jmp;
        logic        br;
        logic        stall;
        logic [31:0] jt;
        logic [31:0] bt;
        logic        exp_flush;
        logic        exp_valid;
        logic        rel;
        logic [31:0] exp_addr;
    } vec_t;

    sb_t         sbq[$];
    vec_t        vt[6];
    int          total = 0;
    int          bad = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic        mem_hold = 1'b0;
    logic        sb_en = 1'b0;

    // 0x00400000 maps to 0x8C220004 (lw $2,4($1)).
    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h8C62_0004;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive_mem();
        imem_rvalid = pend && !mem_hold;
        imem_rdata  = pend ? memf(pend_addr) : 32'h0;
    endtask

    task automatic tick();
        logic        acc, fire;
        logic [31:0] a;
        #1;
        acc  = imem_req && imem_ready;
        a    = imem_addr;
        fire = imem_rvalid;
        @(posedge clk);
        #1;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (fire) pend = 1'b0;
            if (acc) begin
                pend      = 1'b1;
                pend_addr = a;
                if (sb_en) sbq.push_back('{instr: memf(a), pcp4: a + 32'd4});
            end
        end
        drive_mem();
    endtask

    task automatic wait_valid(input int max, input string nm);
        int n = 0;
        #1;
        while (!fetch_validF && n < max) begin
            tick();
            #1;
            n++;
        end
        total++;
        if (!fetch_validF) begin
            bad++;
            $display("FAIL %s timeout actual=%0d cycles required<=%0d", nm, n, max);
        end
    endtask

    initial begin
        sb_t         s;
        logic [31:0] base, exp_a;

        vt[0] = '{jmp:0, br:1, stall:0, jt:32'h0, bt:32'h0040_0103, exp_flush:1, exp_valid:0, rel:0, exp_addr:32'h0040_0100};
        vt[1] = '{jmp:1, br:1, stall:0, jt:32'h100, bt:32'h200, exp_flush:1, exp_valid:0, rel:0, exp_addr:32'h100};
        vt[2] = '{jmp:1, br:0, stall:1, jt:32'h40, bt:32'h0, exp_flush:0, exp_valid:1, rel:1, exp_addr:32'h0};
        vt[3] = '{jmp:0, br:0, stall:0, jt:32'h0, bt:32'h0, exp_flush:0, exp_valid:0, rel:1, exp_addr:32'h4};
        vt[4] = '{jmp:1, br:0, stall:0, jt:32'h43, bt:32'h80, exp_flush:1, exp_valid:0, rel:0, exp_addr:32'h40};
        vt[5] = '{jmp:0, br:1, stall:1, jt:32'h0, bt:32'h300, exp_flush:0, exp_valid:1, rel:1, exp_addr:32'h0};

        rst = 1'b0; stallF = 1'b0; branch_takenD = 1'b0; jumpD = 1'b0;
        branch_targetD = '0; jump_targetD = '0; imem_ready = 1'b1;
        drive_mem();

        // Reset state, with a redirect request that must be ignored.
        #1 rst = 1'b1;
        jumpD = 1'b1; jump_targetD = 32'h123;
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_instr", instructionF, 32'h0);
        chk("rst_pcp4", pc_plus4F, RPC + 32'd4);
        chk("rst_valid", {31'b0, fetch_validF}, 32'h0);
        chk("rst_flush", {31'b0, flushD}, 32'h0);
        tick();
        tick();
        rst = 1'b0; jumpD = 1'b0;

        // Streaming: sequential addresses, fixed cadence, scoreboarded data.
        sb_en = 1'b1;
        for (int c = 0; c < 9; c++) begin
            #1;
            chk($sformatf("stream_valid_c%0d", c), {31'b0, fetch_validF}, {31'b0, (c % P) == P - 1});
            if ((c % P) == P - 1) begin
                if (sbq.size() == 0) begin
                    chk($sformatf("stream_sb_empty_c%0d", c), 32'h0, 32'h1);
                end else begin
                    s = sbq.pop_front();
                    chk($sformatf("stream_instr_c%0d", c), instructionF, s.instr);
                    chk($sformatf("stream_pcp4_c%0d", c), pc_plus4F, s.pcp4);
                end
            end else begin
                chk($sformatf("stream_bubble_c%0d", c), instructionF, 32'h0);
            end
            if ((c % P) == 0) begin
                chk($sformatf("stream_req_c%0d", c), {31'b0, imem_req}, 32'h1);
                chk($sformatf("stream_addr_c%0d", c), imem_addr, RPC + 32'(4 * (c / P)));
            end
            tick();
        end
        sb_en = 1'b0;
        sbq.delete();

        // Stall in the valid state holds everything.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stallF = 1'b1;
        wait_valid(10, "stall_reach");
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("stall_instr_%0d", k), instructionF, 32'h8C22_0004);
            chk($sformatf("stall_pcp4_%0d", k), pc_plus4F, 32'h0040_0004);
            chk($sformatf("stall_req_%0d", k), {31'b0, imem_req}, 32'h0);
            chk($sformatf("stall_addr_%0d", k), imem_addr, RPC);
            tick();
        end
        stallF = 1'b0;
        #1;
        chk("stall_rel_valid", {31'b0, fetch_validF}, 32'h1);
        tick();
        #1;
        chk("stall_rel_req", {31'b0, imem_req}, 32'h1);
        chk("stall_rel_addr", imem_addr, 32'h0040_0004);

        // Jump while waiting for data: the stale response must be dropped.
        mem_hold = 1'b1;
        tick();
        jumpD = 1'b1; jump_targetD = 32'h40;
        #1;
        chk("drop_flush", {31'b0, flushD}, 32'h1);
        chk("drop_valid_wait", {31'b0, fetch_validF}, 32'h0);
        tick();
        jumpD = 1'b0;
        mem_hold = 1'b0;
        drive_mem();
        #1;
        chk("drop_rvalid_seen", {31'b0, imem_rvalid}, 32'h1);
        chk("drop_valid", {31'b0, fetch_validF}, 32'h0);
        chk("drop_instr", instructionF, 32'h0);
        chk("drop_req", {31'b0, imem_req}, 32'h0);
        tick();
        #1;
        chk("drop_next_req", {31'b0, imem_req}, 32'h1);
        chk("drop_next_addr", imem_addr, 32'h40);

        // Redirect/stall vectors applied while an instruction is presented.
        for (int i = 0; i < 6; i++) begin
            base = 32'h0000_1000 + 32'(i) * 32'h100;
            jumpD = 1'b1; jump_targetD = base;
            tick();
            jumpD = 1'b0;
            wait_valid(20, $sformatf("vec%0d_reach", i));
            chk($sformatf("vec%0d_instr", i), instructionF, memf(base));
            jumpD = vt[i].jmp; branch_takenD = vt[i].br; stallF = vt[i].stall;
            jump_targetD = vt[i].jt; branch_targetD = vt[i].bt;
            #1;
            chk($sformatf("vec%0d_flush", i), {31'b0, flushD}, {31'b0, vt[i].exp_flush});
            tick();
            jumpD = 1'b0; branch_takenD = 1'b0; stallF = 1'b0;
            exp_a = vt[i].rel ? base + vt[i].exp_addr : vt[i].exp_addr;
            #1;
            chk($sformatf("vec%0d_valid", i), {31'b0, fetch_validF}, {31'b0, vt[i].exp_valid});
            chk($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, ~vt[i].exp_valid});
            chk($sformatf("vec%0d_addr", i), imem_addr, exp_a);
        end

        // PC wrap at the top of the address space.
        jumpD = 1'b1; jump_targetD = 32'hFFFF_FFFC;
        tick();
        jumpD = 1'b0;
        #1;
        chk("wrap_req", {31'b0, imem_req}, 32'h1);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pcp4", pc_plus4F, 32'h0);
        tick();
        wait_valid(10, "wrap_reach");
        chk("wrap_instr", instructionF, memf(32'hFFFF_FFFC));
        tick();
        #1;
        chk("wrap_next_addr", imem_addr, 32'h0);
        chk("wrap_next_req", {31'b0, imem_req}, 32'h1);

        // Asynchronous reset while a request is outstanding.
        mem_hold = 1'b1;
        tick();
        #1;
        chk("arst_pre_req", {31'b0, imem_req}, 32'h0);
        rst = 1'b1;
        #1;
        chk("arst_req", {31'b0, imem_req}, 32'h0);
        chk("arst_addr", imem_addr, RPC);
        chk("arst_instr", instructionF, 32'h0);
        chk("arst_pcp4", pc_plus4F, RPC + 32'd4);
        chk("arst_valid", {31'b0, fetch_validF}, 32'h0);
        chk("arst_flush", {31'b0, flushD}, 32'h0);
        pend = 1'b0;
        mem_hold = 1'b0;
        drive_mem();
        tick();
        rst = 1'b0;
        #1;
        chk("arst_restart_req", {31'b0, imem_req}, 32'h1);
        chk("arst_restart_addr", imem_addr, RPC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
